// File: rtl/stream_demux_2out.sv
// Two-way stream demultiplexer. Each destination has its own 2-entry skid FIFO
// and an 8-bit delivered-beat counter, so a stalled sink never blocks the other.

module stream_demux_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              out_ready,
  input  logic              cnt_clr,
  output logic              full,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} fifo_st_e;

  fifo_st_e          st;
  logic [DATA_W-1:0] head, tail;
  logic              pop;

  assign out_valid = (st != EMPTY);
  assign full      = (st == TWO);
  assign pop       = out_valid & out_ready;
  // Head is masked so the data bus reads zero whenever nothing is buffered.
  assign out_data  = out_valid ? head : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= EMPTY;
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      unique case (st)
        EMPTY: if (push) begin
          head <= push_data;
          st   <= ONE;
        end
        ONE: begin
          if (push && pop) head <= push_data;
          else if (push) begin
            tail <= push_data;
            st   <= TWO;
          end else if (pop) st <= EMPTY;
        end
        TWO: if (pop) begin
          head <= tail;
          st   <= ONE;
        end
        default: st <= EMPTY;
      endcase
      if (cnt_clr)  cnt <= '0;
      else if (pop) cnt <= cnt + 8'd1;
    end
  end
endmodule

module stream_demux_2out #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [DATA_W-1:0] out1_data,
  output logic              out0_valid,
  output logic              out1_valid,
  input  logic              out0_ready,
  input  logic              out1_ready,
  output logic [7:0]        cnt0,
  output logic [7:0]        cnt1,
  input  logic              cnt_clr
);
  localparam int NUM_OUT = 2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sel;
  } req_t;

  req_t                             req;
  logic [NUM_OUT-1:0]               full, push, o_vld, o_rdy;
  logic [NUM_OUT-1:0][DATA_W-1:0]   o_data;
  logic [NUM_OUT-1:0][7:0]          o_cnt;

  assign req   = '{data: in_data, sel: in_sel};
  assign o_rdy = {out1_ready, out0_ready};
  // Ready depends only on FIFO state and the routing bit, never on sink ready.
  assign in_ready = rst_n & ~full[req.sel];

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_lane
    assign push[g] = in_valid & in_ready & (req.sel == 1'(g));
    stream_demux_lane #(.DATA_W(DATA_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[g]),
      .push_data (req.data),
      .out_ready (o_rdy[g]),
      .cnt_clr   (cnt_clr),
      .full      (full[g]),
      .out_valid (o_vld[g]),
      .out_data  (o_data[g]),
      .cnt       (o_cnt[g])
    );
  end

  assign out0_data  = o_data[0];
  assign out1_data  = o_data[1];
  assign out0_valid = o_vld[0];
  assign out1_valid = o_vld[1];
  assign cnt0       = o_cnt[0];
  assign cnt1       = o_cnt[1];
endmodule
